// File: rtl/display_pkg.sv
// Shared definitions for the display colour encode/decode path.
package display_pkg;

  // Bits per colour channel and width of the sweep cycle counter.
  localparam int unsigned cyclewidth_default = 8;

  // Lane index of each channel within the 3-bit rgb stream.
  localparam int unsigned lane_r = 2;
  localparam int unsigned lane_g = 1;
  localparam int unsigned lane_b = 0;

  typedef enum logic [0:0] {
    IDLE,
    ACCUM
  } state_e;

endpackage

// File: rtl/display_channel_counter.sv
// Per-channel high-sample counter with monotonicity tracking and n-1 decode.
// value/bad reflect the state including the sample presented this cycle, so
// the parent can register them on the same edge the last sample is accepted.
module display_channel_counter
  import display_pkg::*;
#(
  parameter int unsigned cyclewidth = cyclewidth_default
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  din,
  output logic [cyclewidth-1:0] value,
  output logic                  bad
);

  localparam logic [cyclewidth:0] one = (cyclewidth + 1)'(1);

  // Counter is one bit wider: a full-intensity channel is high on all 2^w cycles.
  logic [cyclewidth:0] cnt_q, cnt_d;
  logic                seen_low_q, seen_low_d;
  logic                bad_q, bad_d;
  logic [cyclewidth:0] dec;

  // Next-state: clear restarts the sweep and counts the current sample.
  always_comb begin
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    bad_d      = bad_q;
    if (clear) begin
      cnt_d      = din ? one : '0;
      seen_low_d = ~din;
      bad_d      = 1'b0;
    end else if (en) begin
      if (din) begin
        cnt_d = cnt_q + one;
        if (seen_low_q) bad_d = 1'b1;
      end else begin
        seen_low_d = 1'b1;
      end
    end
  end

  // Decode: n high samples means pixel n-1, except n == 0 means pixel 0.
  always_comb begin
    dec   = (cnt_d == '0) ? '0 : cnt_d - one;
    value = dec[cyclewidth-1:0];
    bad   = bad_d;
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      bad_q      <= bad_d;
    end
  end

endmodule

// File: rtl/display_color_decoder.sv
// Reconstructs packed RGB pixels from one full sweep of encoded rgb bits.
module display_color_decoder
  import display_pkg::*;
#(
  parameter int unsigned cyclewidth = cyclewidth_default
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [cyclewidth-1:0]   in_cycle,
  input  logic [2:0]              in_rgb,
  output logic                    out_valid,
  output logic [3*cyclewidth-1:0] out_pixel,
  output logic                    out_error,
  output logic                    out_abort
);

  localparam logic [cyclewidth-1:0] last_cycle = '1;
  localparam logic [cyclewidth-1:0] one_cycle  = cyclewidth'(1);

  state_e                state;
  logic [cyclewidth-1:0] expected;

  logic                  start;  // clear counters and count this sample
  logic                  en;     // in-sequence sample inside a sweep
  logic                  done;   // in-sequence sample that closes the sweep
  logic                  abort;  // sequence break inside a sweep

  logic [cyclewidth-1:0] value [3];
  logic [2:0]            bad;

  // Classify the current sample against the sweep state.
  always_comb begin
    start = 1'b0;
    en    = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    unique case (state)
      IDLE: begin
        start = in_valid && (in_cycle == '0);
      end
      ACCUM: begin
        if (in_valid) begin
          if (in_cycle == expected) begin
            en   = 1'b1;
            done = (in_cycle == last_cycle);
          end else begin
            abort = 1'b1;
            start = (in_cycle == '0);
          end
        end
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    display_channel_counter #(
      .cyclewidth(cyclewidth)
    ) u_counter (
      .clk  (clk),
      .rst  (rst),
      .clear(start),
      .en   (en),
      .din  (in_rgb[gi]),
      .value(value[gi]),
      .bad  (bad[gi])
    );
  end

  // Sweep FSM, expected-cycle tracking and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      expected  <= '0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      out_abort <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_valid <= done;
      out_abort <= abort;
      out_error <= done && (|bad);
      if (done) begin
        out_pixel <= {value[lane_r], value[lane_g], value[lane_b]};
      end
      if (start) begin
        state    <= ACCUM;
        expected <= one_cycle;
      end else if (en) begin
        // Wraps to 0 after the last cycle; unused once back in IDLE.
        expected <= expected + one_cycle;
        if (done) state <= IDLE;
      end else if (abort) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_display_color_decoder.sv
// Directed bench for display_color_decoder: table of full sweeps plus
// hand-written abort, reset and back-to-back sequences.
module tb_display_color_decoder;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_cycle = '0;
  logic [2:0]     in_rgb = '0;
  logic           out_valid;
  logic [3*W-1:0] out_pixel;
  logic           out_error;
  logic           out_abort;

  display_color_decoder #(
    .cyclewidth(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_cycle (in_cycle),
    .in_rgb   (in_rgb),
    .out_valid(out_valid),
    .out_pixel(out_pixel),
    .out_error(out_error),
    .out_abort(out_abort)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int abort_cnt = 0;
  int viol = 0;

  // Pulse counters and output-protocol watch.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) valid_cnt++;
      if (out_abort) abort_cnt++;
      if (out_valid && out_abort) viol++;
      if (!out_valid && out_error) viol++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Encoder law: bit = (p >= cycle) && (p != 0).
  function automatic logic enc_ch(input logic [7:0] p, input int c);
    return (int'(p) >= c) && (p != 8'd0);
  endfunction

  function automatic logic [2:0] enc(input logic [23:0] px, input bit redpat, input int c);
    if (redpat) return {(c < 10 || c >= 20), 2'b00};
    return {enc_ch(px[23:16], c), enc_ch(px[15:8], c), enc_ch(px[7:0], c)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int c, input logic [2:0] rgb);
    in_valid = 1'b1;
    in_cycle = W'(c);
    in_rgb   = rgb;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  // Drive cycles first..255, optionally with 1..gapmax idle clocks between samples.
  task automatic sweep_body(input logic [23:0] px, input bit redpat, input int gapmax,
                            input int first);
    for (int c = first; c < 256; c++) begin
      if (gapmax > 0 && c != first) gap(int'($urandom_range(1, gapmax)));
      tick();
      drive(c, enc(px, redpat, c));
    end
  endtask

  // One clock after the last driven sample: outputs reflect it here.
  task automatic finish_sweep();
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [23:0] px;
    bit          redpat;
    int          gapmax;
    logic [23:0] exp_px;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, a0;

    vecs[0] = '{"black",   24'h000000, 1'b0, 0, 24'h000000, 1'b0};
    vecs[1] = '{"ff8001",  24'hFF8001, 1'b0, 0, 24'hFF8001, 1'b0};
    vecs[2] = '{"gaps",    24'h010203, 1'b0, 5, 24'h010203, 1'b0};
    vecs[3] = '{"redbad",  24'h000000, 1'b1, 0, 24'hF50000, 1'b1};
    vecs[4] = '{"mixed",   24'h123456, 1'b0, 2, 24'h123456, 1'b0};
    vecs[5] = '{"white",   24'hFFFFFF, 1'b0, 0, 24'hFFFFFF, 1'b0};

    // Reset state.
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pixel", 64'(out_pixel), 64'd0);
    check("rst_error", 64'(out_error), 64'd0);
    check("rst_abort", 64'(out_abort), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven full sweeps.
    foreach (vecs[i]) begin
      v0 = valid_cnt;
      a0 = abort_cnt;
      sweep_body(vecs[i].px, vecs[i].redpat, vecs[i].gapmax, 0);
      finish_sweep();
      check({vecs[i].name, "_valid_lat"}, 64'(out_valid), 64'd1);
      check({vecs[i].name, "_pixel"}, 64'(out_pixel), 64'(vecs[i].exp_px));
      check({vecs[i].name, "_error"}, 64'(out_error), 64'(vecs[i].exp_err));
      tick();
      check({vecs[i].name, "_valid_pulse"}, 64'(out_valid), 64'd0);
      check({vecs[i].name, "_pixel_hold"}, 64'(out_pixel), 64'(vecs[i].exp_px));
      tick();
      check({vecs[i].name, "_valid_cnt"}, 64'(valid_cnt - v0), 64'd1);
      check({vecs[i].name, "_abort_cnt"}, 64'(abort_cnt - a0), 64'd0);
    end

    // Sweep broken at cycle 100 by a cycle-0 sample that restarts it.
    v0 = valid_cnt;
    a0 = abort_cnt;
    for (int c = 0; c < 100; c++) begin
      tick();
      drive(c, enc(24'h7F7F7F, 1'b0, c));
    end
    tick();
    drive(0, enc(24'h7F7F7F, 1'b0, 0));
    tick();
    check("restart_abort", 64'(out_abort), 64'd1);
    check("restart_no_valid", 64'(out_valid), 64'd0);
    drive(1, enc(24'h7F7F7F, 1'b0, 1));
    sweep_body(24'h7F7F7F, 1'b0, 0, 2);
    finish_sweep();
    check("restart_valid", 64'(out_valid), 64'd1);
    check("restart_pixel", 64'(out_pixel), 64'h7F7F7F);
    check("restart_error", 64'(out_error), 64'd0);
    gap(2);
    check("restart_valid_cnt", 64'(valid_cnt - v0), 64'd1);
    check("restart_abort_cnt", 64'(abort_cnt - a0), 64'd1);

    // Skip 50 -> 52: abort, then ignore everything until the next cycle 0.
    v0 = valid_cnt;
    a0 = abort_cnt;
    for (int c = 0; c <= 50; c++) begin
      tick();
      drive(c, enc(24'h203040, 1'b0, c));
    end
    tick();
    drive(52, enc(24'h203040, 1'b0, 52));
    tick();
    check("skip_abort", 64'(out_abort), 64'd1);
    drive(53, enc(24'h203040, 1'b0, 53));
    sweep_body(24'h203040, 1'b0, 0, 54);
    finish_sweep();
    check("skip_no_valid", 64'(out_valid), 64'd0);
    gap(2);
    check("skip_valid_cnt", 64'(valid_cnt - v0), 64'd0);
    check("skip_abort_cnt", 64'(abort_cnt - a0), 64'd1);
    check("skip_pixel_hold", 64'(out_pixel), 64'h7F7F7F);

    // Reset at cycle 128, then the rest of the sweep must be ignored.
    v0 = valid_cnt;
    a0 = abort_cnt;
    for (int c = 0; c <= 128; c++) begin
      tick();
      drive(c, enc(24'h55AA33, 1'b0, c));
    end
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_pixel", 64'(out_pixel), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_abort", 64'(out_abort), 64'd0);
    tick();
    rst = 1'b0;
    sweep_body(24'h55AA33, 1'b0, 0, 129);
    finish_sweep();
    gap(2);
    check("midrst_valid_cnt", 64'(valid_cnt - v0), 64'd0);
    check("midrst_abort_cnt", 64'(abort_cnt - a0), 64'd0);
    check("midrst_pixel_after", 64'(out_pixel), 64'd0);
    sweep_body(24'h55AA33, 1'b0, 0, 0);
    finish_sweep();
    check("postrst_valid", 64'(out_valid), 64'd1);
    check("postrst_pixel", 64'(out_pixel), 64'h55AA33);

    // Back-to-back sweeps: next cycle 0 arrives while out_valid is high.
    gap(2);
    v0 = valid_cnt;
    sweep_body(24'h0A0B0C, 1'b0, 0, 0);
    tick();
    drive(0, enc(24'hC0FFEE, 1'b0, 0));
    check("b2b_first_valid", 64'(out_valid), 64'd1);
    check("b2b_first_pixel", 64'(out_pixel), 64'h0A0B0C);
    sweep_body(24'hC0FFEE, 1'b0, 0, 1);
    finish_sweep();
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_pixel", 64'(out_pixel), 64'hC0FFEE);
    gap(2);
    check("b2b_valid_cnt", 64'(valid_cnt - v0), 64'd2);

    check("protocol_violations", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
